// File: rtl/dsp_pkg.sv
// Shared DSP helpers for the up/down converters: width derivation and Q-format limits.
package dsp_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Full-precision FIR accumulator width: sample + coefficient + tap growth.
  function automatic int acc_w(input int dw, input int cw, input int taps);
    return dw + cw + clog2(taps);
  endfunction

  function automatic logic [63:0] q_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] q_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/upconv_mix.sv
// Registered mixer: rf = f*lo renormalised to Q1.(DWIDTH-1); (-1)*(-1) clamps to max positive.
module upconv_mix
  import dsp_pkg::*;
#(
  parameter int DWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DWIDTH-1:0] f,
  input  logic signed [DWIDTH-1:0] lo,
  input  logic                     vld_p1,
  output logic signed [DWIDTH-1:0] rf_out,
  output logic                     rf_valid
);

  localparam int PW = 2 * DWIDTH;
  localparam logic [63:0] MAX64 = q_max(DWIDTH);
  localparam logic [63:0] MIN64 = q_min(DWIDTH);
  localparam logic signed [DWIDTH-1:0] QMAX = MAX64[DWIDTH-1:0];
  localparam logic signed [DWIDTH-1:0] QMIN = MIN64[DWIDTH-1:0];

  function automatic logic signed [DWIDTH-1:0] norm(input logic signed [DWIDTH-1:0] a,
                                                    input logic signed [DWIDTH-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    if (a == QMIN && b == QMIN) return QMAX;
    return p[PW-2 -: DWIDTH];
  endfunction

  // Stage 2: normalised product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_out   <= '0;
      rf_valid <= 1'b0;
    end else begin
      rf_out   <= norm(f, lo);
      rf_valid <= vld_p1;
    end
  end

endmodule

// File: rtl/upconv.sv
// Digital upconverter: hold register + zero-stuffing interpolator, FIR image reject, LO mixer.
// Define UPCONV_SAT_EN to saturate the FIR output slice instead of wrapping.
module upconv
  import dsp_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int INTERP     = 4,
  parameter int FIR_TAPS   = 64,
  parameter int FIR_CWIDTH = 16,
  parameter int FIR_SLICE  = 36
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FIR_TAPS*FIR_CWIDTH-1:0] fir_coefs,
  input  logic signed [DWIDTH-1:0]       bb_in,
  input  logic                           bb_valid,
  output logic                           bb_ready,
  input  logic signed [DWIDTH-1:0]       lo,
  output logic signed [DWIDTH-1:0]       rf_out,
  output logic                           rf_valid,
  output logic                           underflow
);

  localparam int ACC_W = acc_w(DWIDTH, FIR_CWIDTH, FIR_TAPS);
  localparam int PH_W  = clog2(INTERP);
  localparam int PW    = DWIDTH + FIR_CWIDTH;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(INTERP - 1);
`ifdef UPCONV_SAT_EN
  localparam logic [63:0] MAX64 = q_max(DWIDTH);
  localparam logic [63:0] MIN64 = q_min(DWIDTH);
  localparam logic signed [DWIDTH-1:0] QMAX = MAX64[DWIDTH-1:0];
  localparam logic signed [DWIDTH-1:0] QMIN = MIN64[DWIDTH-1:0];
`endif

  logic [PH_W-1:0]                phase;
  logic                           consume;
  logic                           accept;
  logic                           hold_full;
  logic signed [DWIDTH-1:0]       hold_data;
  logic                           started;
  logic signed [DWIDTH-1:0]       x_p0 [FIR_TAPS];
  logic signed [FIR_CWIDTH-1:0]   coef [FIR_TAPS];
  logic signed [ACC_W-1:0]        sum;
  logic signed [ACC_W-1:0]        acc_p1;
  logic                           vld_p1;
  logic signed [DWIDTH-1:0]       f_p1;

  function automatic logic signed [DWIDTH-1:0] slice_f(input logic signed [ACC_W-1:0] a);
    logic signed [DWIDTH-1:0] s;
    s = a[FIR_SLICE-1 -: DWIDTH];
`ifdef UPCONV_SAT_EN
    // Discarded MSBs must all match the slice sign bit, otherwise clamp by true sign.
    for (int i = FIR_SLICE; i < ACC_W; i++)
      if (a[i] != a[FIR_SLICE-1]) s = a[ACC_W-1] ? QMIN : QMAX;
`endif
    return s;
  endfunction

  assign consume  = (phase == '0);
  assign bb_ready = !hold_full || consume;
  assign accept   = bb_valid && bb_ready;

  for (genvar k = 0; k < FIR_TAPS; k++) begin : g_coef
    assign coef[k] = fir_coefs[k*FIR_CWIDTH +: FIR_CWIDTH];
  end

  // Stage 0: rate control, hold register and zero-stuffed delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      started   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      // A same-cycle accept refills the hold while its old content moves into x_p0[0].
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= bb_in;
      end else if (consume) begin
        hold_full <= 1'b0;
      end
      if (consume && hold_full) started <= 1'b1;
      if (consume && !hold_full && started) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < FIR_TAPS; k++) x_p0[k] <= '0;
    end else begin
      x_p0[0] <= (consume && hold_full) ? hold_data : '0;
      for (int k = 1; k < FIR_TAPS; k++) x_p0[k] <= x_p0[k-1];
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < FIR_TAPS; k++)
      sum = sum + ACC_W'(PW'(x_p0[k]) * PW'(coef[k]));
  end

  // Stage 1: full-precision FIR accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      acc_p1 <= sum;
      vld_p1 <= started;
    end
  end

  assign f_p1 = slice_f(acc_p1);

  upconv_mix #(
    .DWIDTH(DWIDTH)
  ) u_mix (
    .clk     (clk),
    .rst     (rst),
    .f       (f_p1),
    .lo      (lo),
    .vld_p1  (vld_p1),
    .rf_out  (rf_out),
    .rf_valid(rf_valid)
  );

endmodule
